// File: rtl/rv_pkg.sv
// Shared RV32 pipeline types and constants for the register-file write port.
package rv_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wport_req_t;

  // Saturating increment for the 4-bit starvation counters.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a force override; the pointer advances past every winner.
module rr_arbiter
  import rv_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic          force_en,
  input  logic [IW-1:0] force_idx,
  output logic [N-1:0]  grant
);

  localparam int unsigned NU = N;

  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [IW-1:0] cand;
  logic          found;

  // Pick the winner: forced index when overridden, else first request at or after ptr.
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    cand  = '0;
    if (en) begin
      if (force_en) begin
        if (req[force_idx]) begin
          grant[force_idx] = 1'b1;
          win              = force_idx;
          found            = 1'b1;
        end
      end else begin
        for (int unsigned k = 0; k < NU; k++) begin
          cand = IW'((32'(ptr) + k) % NU);
          if (!found && req[cand]) begin
            grant[cand] = 1'b1;
            win         = cand;
            found       = 1'b1;
          end
        end
      end
    end
  end

  // Advance the pointer to the slot after the winner, wrapping at N.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (32'(win) == NU - 1) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port owner: WB vs. aux producers, pending-write scoreboard,
// and starvation-forced WB bubbles.
module regfile_wport_arbiter
  import rv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int NUM_AUX      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wb_we,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic [XLEN-1:0]           wb_wd,
  output logic                      wb_stall,
  input  logic [NUM_AUX-1:0]        aux_req,
  input  logic [REG_AW*NUM_AUX-1:0] aux_rd,
  input  logic [XLEN*NUM_AUX-1:0]   aux_wd,
  output logic [NUM_AUX-1:0]        aux_ack,
  input  logic                      iss_valid,
  input  logic [REG_AW-1:0]         iss_rd,
  output logic                      iss_ready,
  input  logic [REG_AW-1:0]         dec_rs1,
  input  logic [REG_AW-1:0]         dec_rs2,
  input  logic [REG_AW-1:0]         dec_rd,
  input  logic                      dec_use1,
  input  logic                      dec_use2,
  input  logic                      dec_wr,
  output logic                      hazard_stall,
  output logic [REG_AW-1:0]         rf_a3,
  output logic [XLEN-1:0]           rf_wd3,
  output logic                      rf_we3
);

  localparam int AIW = (NUM_AUX > 1) ? $clog2(NUM_AUX) : 1;
  localparam int PW  = rv_pkg::XLEN;

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [3:0]          starve_cnt [NUM_AUX];
  logic [3:0]          starve_nxt [NUM_AUX];
  logic                force_q;
  logic                force_nxt;
  logic [AIW-1:0]      force_idx;
  logic [AIW-1:0]      force_idx_nxt;
  logic                starved;
  logic                wb_grant;
  logic                aux_en;
  logic                issue_ok;
  logic [NUM_AUX-1:0]  aux_grant;
  wport_req_t          port;

  // wb_stall comes only from force_q, so there is no path from the wb_* inputs.
  assign wb_stall = force_q;
  assign wb_grant = rst_n & wb_we & ~force_q;
  assign aux_en   = rst_n & ~wb_grant;

  rr_arbiter #(
    .N  (NUM_AUX),
    .IW (AIW)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (aux_req),
    .en        (aux_en),
    .force_en  (force_q),
    .force_idx (force_idx),
    .grant     (aux_grant)
  );

  assign aux_ack = aux_grant;

  // Zero-latency port mux: WB first, else the arbitrated aux requester.
  always_comb begin
    port = '0;
    if (wb_grant) begin
      port.we = 1'b1;
      port.rd = wb_rd;
      port.wd = PW'(wb_wd);
    end else begin
      for (int unsigned i = 0; i < NUM_AUX; i++) begin
        if (aux_grant[i]) begin
          port.we = 1'b1;
          port.rd = aux_rd[i*REG_AW +: REG_AW];
          port.wd = PW'(aux_wd[i*XLEN +: XLEN]);
        end
      end
    end
  end

  // x0 grants are consumed/acked but never reach the array.
  assign rf_we3 = port.we & (port.rd != ZERO_REG);
  assign rf_a3  = port.rd;
  assign rf_wd3 = XLEN'(port.wd);

  // Next starvation counts and force request (lowest starved index wins).
  // The force fires in the same cycle the counter register shows STARVE_LIMIT,
  // hence the comparison on the next-state value.
  always_comb begin
    starved       = 1'b0;
    force_idx_nxt = '0;
    for (int unsigned i = 0; i < NUM_AUX; i++) begin
      starve_nxt[i] = (aux_req[i] && !aux_grant[i]) ? sat_inc4(starve_cnt[i]) : 4'd0;
      if (!starved && starve_nxt[i] >= 4'(STARVE_LIMIT)) begin
        starved       = 1'b1;
        force_idx_nxt = AIW'(i);
      end
    end
    force_nxt = starved & ~force_q;
  end

  // Starvation counters and the one-cycle force flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_AUX; i++) starve_cnt[i] <= '0;
      force_q   <= 1'b0;
      force_idx <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_AUX; i++) starve_cnt[i] <= starve_nxt[i];
      force_q   <= force_nxt;
      force_idx <= force_idx_nxt;
    end
  end

  assign iss_ready    = ~busy[iss_rd] | (iss_rd == ZERO_REG);
  assign issue_ok     = iss_valid & iss_ready & (iss_rd != ZERO_REG);
  assign hazard_stall = (dec_use1 & busy[dec_rs1]) |
                        (dec_use2 & busy[dec_rs2]) |
                        (dec_wr   & busy[dec_rd]);

  // Scoreboard set/clear vectors from issue and aux completion.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_ok) set_vec[iss_rd] = 1'b1;
    for (int unsigned i = 0; i < NUM_AUX; i++) begin
      if (aux_grant[i] && aux_rd[i*REG_AW +: REG_AW] != ZERO_REG)
        clr_vec[aux_rd[i*REG_AW +: REG_AW]] = 1'b1;
    end
  end

  // Pending-write scoreboard; clear wins over set, x0 is never pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy    <= (busy | set_vec) & ~clr_vec;
      busy[0] <= 1'b0;
    end
  end

  a_no_set_clr_same_reg : assert property (
    @(posedge clk) disable iff (!rst_n) (set_vec & clr_vec) == '0
  );

  a_ack_onehot : assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(aux_ack)
  );

endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Owns the single write port (A3/WD3/WE3) of the 32x32 register file in the 5-stage RV32 pipeline.
- Shares that port between the in-order WB stage and NUM_AUX long-latency producers (multi-cycle MDU, miss-return load unit).
- Keeps a per-register pending-write scoreboard that blocks decode on RAW/WAW hazards against outstanding aux writes.
- Forces a WB bubble when an aux requester has been starved too long.

Parameters:
- XLEN, 32, data width.
- NUM_AUX, 2, number of auxiliary write requesters (1..4).
- STARVE_LIMIT, 4, cycles an aux request may wait before WB is stalled for it (1..15).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- wb_we  in  1  WB stage write request; always accepted when wb_stall=0.
- wb_rd  in  5  WB destination register.
- wb_wd  in  XLEN  WB write data.
- wb_stall  out  1  freezes the WB stage and upstream this cycle.
- aux_req  in  NUM_AUX  per-requester write request; held until ack.
- aux_rd  in  5*NUM_AUX  per-requester destination, packed.
- aux_wd  in  XLEN*NUM_AUX  per-requester data, packed.
- aux_ack  out  NUM_AUX  one-hot; write performed this cycle.
- iss_valid  in  1  decode issuing an instruction to an aux unit.
- iss_rd  in  5  destination of that issue.
- iss_ready  out  1  issue accepted.
- dec_rs1, dec_rs2, dec_rd  in  5 each  decode-stage register indices.
- dec_use1, dec_use2, dec_wr  in  1 each  corresponding index valid.
- hazard_stall  out  1  decode must stall.
- rf_a3  out  5  to register file A3.
- rf_wd3  out  XLEN  to register file WD3.
- rf_we3  out  1  to register file WE3.

Behaviour:
- State: busy[31:0] scoreboard, rr_ptr (round-robin pointer over aux), starve_cnt per aux (4 bits), force_q (1 bit), force_idx.
- Reset: all state 0.
- Reset-time outputs: wb_stall=0, aux_ack=0, rf_we3=0, rf_a3=0, rf_wd3=0, iss_ready=1, hazard_stall=0.
- Port mux is combinational, zero latency. Grant, ack and rf_* are valid in the same cycle, because the register file writes on the following negedge.
- Normal priority: if wb_stall=0 and wb_we=1, WB owns the port and all aux_ack=0.
- Otherwise the port goes to the round-robin winner among aux_req, searching from rr_ptr upward with wrap.
- On an aux grant, rr_ptr <= winner+1 (mod NUM_AUX).
- Starvation counting: starve_cnt[i] increments (saturating) each cycle aux_req[i]=1 and aux_ack[i]=0, and clears on ack or when req is low.
- Starvation trigger: when any starve_cnt reaches STARVE_LIMIT, set force_q=1 and force_idx=the lowest such i.
- Forced cycle: when force_q=1, wb_stall=1 and the port goes to force_idx regardless of rr_ptr. force_q clears next cycle. rr_ptr is still updated.
- wb_stall is asserted only in force_q cycles; it is registered-derived and has no combinational path from the wb_* inputs.
- x0 writes: any grant with rd=0 drives rf_we3=0 and still asserts the ack (WB is consumed, aux is acked). busy[0] is never set.
- Issue: iss_ready = !busy[iss_rd] | (iss_rd==0). On iss_valid & iss_ready with iss_rd!=0, busy[iss_rd] <= 1.
- Aux completion: aux_ack[i] with aux_rd[i]!=0 clears busy[aux_rd[i]].
- Same-register set and clear in one cycle cannot occur, since issue is blocked while busy. If it does occur, the clear applies and an assertion fires.
- Decode hazard: hazard_stall = (dec_use1 & busy[dec_rs1]) | (dec_use2 & busy[dec_rs2]) | (dec_wr & busy[dec_rd]). Index 0 never hazards.
- No bypass from an aux write in flight: a register becomes readable the cycle after its ack, which is when busy clears.
- Reset mid-operation: all pending busy bits and counters drop immediately; outstanding aux requests are the producers' responsibility to flush.

Decomposition:
- Shared package rv_pkg holds: XLEN, REG_AW=5, NUM_REGS=32, ZERO_REG=0, and a wport_req_t struct {we, rd, wd}.
- One natural sub-module, rr_arbiter, holds the parameterised round-robin with pointer, request vector, one-hot grant and a force input. The scoreboard stays inline.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> all outputs at reset values. Release, then issue rd=5 -> busy[5]=1; decode rs1=5 -> hazard_stall=1.
- Contention: wb_we=1 (rd=3, 0xAAAA) with aux_req=2'b01 (rd=5, 0x1234) -> cycle 0 writes x3. Drop wb_we -> next cycle aux_ack=01 writes x5=0x1234, busy[5] clears, hazard_stall drops the following cycle.
- Round-robin: both aux requesting continuously with wb idle -> acks alternate 01,10,01,10 starting from rr_ptr=0.
- Starvation: wb_we=1 every cycle, aux_req[1]=1 -> after STARVE_LIMIT=4 waiting cycles, wb_stall=1 for exactly one cycle and aux_ack=10 in that cycle; WB write resumes next cycle.
- x0 and WAW: aux write rd=0 -> ack=1, rf_we3=0. Issue rd=7 twice -> second iss_ready=0 until the first rd=7 ack. dec_rd=7 with dec_wr=1 -> hazard_stall=1.
- Async reset mid-stream with busy[9]=1 and a starve count of 3 -> busy and counters are 0 immediately, without waiting for a clock edge.
